// File: rtl/riscv_pkg.sv
// Shared RV32I sequencer types: opcode/funct3 constants, sequencer states, trap causes.
// Latency: none, types and constants only.
// Backpressure: not applicable.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
   localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } seq_state_t;

   // Opcodes this sequencer knows how to step through
   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive stall cycles of a memory access and flags when the limit is reached.
// Latency: expired reflects the registered count, one cycle after each counted stall.
// Backpressure: none; counting saturates at the limit until cleared.
module wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic cnt_en,
   output logic expired
);

   localparam int W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

   logic [W-1:0] cnt_q, cnt_d;

   // clear wins over counting; hold at the limit so the count never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_en && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // stall counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// RV32I multi-cycle sequencer: steps fetch/decode/exec/mem/wb, counts retires, traps on faults.
// Latency: branch 3, R/I 4, store 4, load 5 cycles; each memory stall cycle adds one.
// Backpressure: imem_req/dmem_req hold until ready; MEM_TIMEOUT stalls in a row trap the core.
module multicycle_sequencer
   import riscv_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        alu_zero,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        rf_we,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [2:0]  state_o,
   output logic [31:0] instret
);

   seq_state_t  state_q, state_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] instret_q, instret_d;
   logic        retire;
   logic        waiting;
   logic        port_ready;
   logic        tmr_expired;

   // Only the port of the current phase matters; the counter restarts whenever
   // that port completes or we are not waiting, so every FETCH/MEM entry starts at 0.
   assign waiting    = (state_q == S_FETCH) || (state_q == S_MEM);
   assign port_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;

   wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!waiting || port_ready),
      .cnt_en  (waiting && !port_ready),
      .expired (tmr_expired)
   );

   // next state, trap cause and per-phase strobes decoded from the current state
   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      rf_we      = 1'b0;
      trap       = 1'b0;
      trap_cause = cause_q;
      retire     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (tmr_expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_IMEM_TO;
            end
         end
         S_DECODE: begin
            if (is_legal_op(opcode)) begin
               state_d = S_EXEC;
            end else begin
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_EXEC: begin
            case (opcode)
               OP_BRANCH: begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
                  case (funct3)
                     F3_BEQ:  pc_sel = alu_zero;
                     F3_BNE:  pc_sel = !alu_zero;
                     default: pc_sel = 1'b0;
                  endcase
               end
               OP_R, OP_I:        state_d = S_WB;
               OP_LOAD, OP_STORE: state_d = S_MEM;
               default: begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_STORE);
            if (dmem_ready) begin
               if (opcode == OP_STORE) begin
                  pc_we   = 1'b1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmr_expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_DMEM_TO;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: trap = 1'b1;
         default: begin
            // unreachable encodings behave as an illegal-opcode trap
            trap       = 1'b1;
            trap_cause = CAUSE_ILLEGAL;
            state_d    = S_TRAP;
            cause_d    = CAUSE_ILLEGAL;
         end
      endcase
   end

   // retired-instruction counter advances with the retiring PC write, wrapping at 2^32
   always_comb begin
      instret_d = instret_q;
      if (retire) begin
         instret_d = instret_q + 32'd1;
      end
   end

   // sequencer state, sticky trap cause and retire count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cause_q   <= CAUSE_NONE;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
      end
   end

   assign state_o = state_q;
   assign instret = instret_q;

endmodule
